// File: rtl/axonerve_wordcount_axi_mem_slave.sv
// rtl/axonerve_wordcount_axi_mem_slave.sv - AXI4 INCR-burst slave backed by on-chip word memory
// Independent read and write FSMs, one burst in flight per direction.
module axonerve_wordcount_axi_mem_slave #(
  parameter int C_S_AXI_ADDR_WIDTH = 64,
  parameter int C_S_AXI_DATA_WIDTH = 512,
  parameter int C_MEM_DEPTH        = 1024
) (
  input  logic                            ap_clk,
  input  logic                            areset,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                            s_axi_rlast,
  output logic                            err_wlast
);

  localparam int NB  = C_S_AXI_DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = $clog2(C_MEM_DEPTH);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];

  logic [1:0]    w_state;
  logic [IW-1:0] w_idx;
  logic [7:0]    w_len;
  logic [7:0]    w_beat;
  logic          w_fire;
  logic          w_is_last;

  logic [0:0]    r_state;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] r_idx_next;
  logic [7:0]    r_len;
  logic [7:0]    r_beat;

  // Address bits outside the word index are deliberately ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

  assign s_axi_awready = (w_state == W_IDLE);
  assign s_axi_wready  = (w_state == W_DATA);
  assign s_axi_bvalid  = (w_state == W_RESP);
  assign s_axi_arready = (r_state == R_IDLE);

  assign w_fire     = s_axi_wvalid && (w_state == W_DATA);
  assign w_is_last  = (w_beat == w_len);
  assign r_idx_next = r_idx + 1'b1;

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      w_state   <= W_IDLE;
      w_idx     <= '0;
      w_len     <= '0;
      w_beat    <= '0;
      err_wlast <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_axi_awvalid) begin
            w_idx   <= s_axi_awaddr[LSB +: IW];
            w_len   <= s_axi_awlen;
            w_beat  <= '0;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (s_axi_wvalid) begin
            // wlast is only audited; awlen alone decides the burst length.
            if (s_axi_wlast != w_is_last) err_wlast <= 1'b1;
            w_idx  <= w_idx + 1'b1;
            w_beat <= w_beat + 8'd1;
            if (w_is_last) w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_axi_bready) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!areset && w_fire) begin
      for (int b = 0; b < NB; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // rdata is registered from mem in the same edge as any write, giving read-first.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      r_state      <= R_IDLE;
      r_idx        <= '0;
      r_len        <= '0;
      r_beat       <= '0;
      s_axi_rvalid <= 1'b0;
      s_axi_rlast  <= 1'b0;
      s_axi_rdata  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi_arvalid) begin
            r_idx        <= s_axi_araddr[LSB +: IW];
            r_len        <= s_axi_arlen;
            r_beat       <= '0;
            s_axi_rdata  <= mem[s_axi_araddr[LSB +: IW]];
            s_axi_rvalid <= 1'b1;
            s_axi_rlast  <= (s_axi_arlen == 8'd0);
            r_state      <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid <= 1'b0;
              s_axi_rlast  <= 1'b0;
              r_state      <= R_IDLE;
            end else begin
              r_idx       <= r_idx_next;
              r_beat      <= r_beat + 8'd1;
              s_axi_rdata <= mem[r_idx_next];
              s_axi_rlast <= ((r_beat + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axonerve_wordcount_axi_mem_slave.sv
// tb/tb_axonerve_wordcount_axi_mem_slave.sv - directed bench with a word-array memory model
// Reads are scored beat by beat against the model by one negedge monitor.
module tb_axonerve_wordcount_axi_mem_slave;

  localparam int AW    = 64;
  localparam int DW    = 512;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic          awvalid = 1'b0, awready;
  logic [AW-1:0] awaddr = '0;
  logic [7:0]    awlen = '0;
  logic          wvalid = 1'b0, wready;
  logic [DW-1:0] wdata = '0;
  logic [NB-1:0] wstrb = '0;
  logic          wlast = 1'b0;
  logic          bvalid, bready = 1'b0;
  logic          arvalid = 1'b0, arready;
  logic [AW-1:0] araddr = '0;
  logic [7:0]    arlen = '0;
  logic          rvalid, rready = 1'b0;
  logic [DW-1:0] rdata;
  logic          rlast;
  logic          err_wlast;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_q[$];
  logic          exp_last_q[$];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] wq[$];
  logic [NB-1:0] sq[$];

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  axonerve_wordcount_axi_mem_slave #(
    .C_S_AXI_ADDR_WIDTH(AW),
    .C_S_AXI_DATA_WIDTH(DW),
    .C_MEM_DEPTH(DEPTH)
  ) dut (
    .ap_clk(clk), .areset(areset),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wlast(wlast), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rlast(rlast),
    .err_wlast(err_wlast)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out", name);
  endtask

  always @(negedge clk) begin
    if (areset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_rvalid", DW'(rvalid), DW'(1));
        check("stall_rdata", rdata, prev_data);
        check("stall_rlast", DW'(rlast), DW'(prev_last));
      end
      if (rvalid && rready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_read_beat");
        end else begin
          check("rdata", rdata, exp_q.pop_front());
          check("rlast", DW'(rlast), DW'(exp_last_q.pop_front()));
          got_q.push_back(rdata);
        end
      end
      prev_stall <= rvalid && !rready;
      prev_data  <= rdata;
      prev_last  <= rlast;
    end
  end

  task automatic do_write(input logic [AW-1:0] addr, input int bad_beat, input int bhold);
    int n;
    int idx;
    int t_aw;
    int cyc;
    n   = wq.size();
    idx = int'(addr[15:6]);
    awaddr  = addr;
    awlen   = 8'(n - 1);
    awvalid = 1'b1;
    cyc = 0;
    while (!awready && cyc < 20) begin @(posedge clk); #1; cyc++; end
    if (!awready) fail_now("aw_wait");
    @(posedge clk); #1;
    t_aw = cycle;
    awvalid = 1'b0;
    for (int i = 0; i < n; i++) begin
      wvalid = 1'b1;
      wdata  = wq[i];
      wstrb  = sq[i];
      wlast  = (bad_beat >= 0) ? (i == bad_beat) : (i == n - 1);
      cyc = 0;
      while (!wready && cyc < 20) begin @(posedge clk); #1; cyc++; end
      if (!wready) fail_now("w_wait");
      @(posedge clk);
      for (int b = 0; b < NB; b++)
        if (sq[i][b]) model_mem[idx][b*8 +: 8] = wq[i][b*8 +: 8];
      idx = (idx + 1) % DEPTH;
      #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    check("bvalid_up", DW'(bvalid), DW'(1));
    check("b_latency", DW'(cycle - t_aw), DW'(n));
    for (int k = 0; k < bhold; k++) begin
      check("bvalid_hold", DW'(bvalid), DW'(1));
      check("awready_hold", DW'(awready), DW'(0));
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("bvalid_drop", DW'(bvalid), DW'(0));
    check("awready_back", DW'(awready), DW'(1));
    wq.delete();
    sq.delete();
  endtask

  // mode 0: rready held high; mode 1: rready toggles; mode 2: reset after two beats
  task automatic do_read(input logic [AW-1:0] addr, input int n, input int mode);
    int idx;
    int t_ar;
    int cyc;
    bit was_reset;
    idx = int'(addr[15:6]);
    got_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_mem[(idx + i) % DEPTH]);
      exp_last_q.push_back(i == n - 1);
    end
    araddr  = addr;
    arlen   = 8'(n - 1);
    arvalid = 1'b1;
    cyc = 0;
    while (!arready && cyc < 20) begin @(posedge clk); #1; cyc++; end
    if (!arready) fail_now("ar_wait");
    @(posedge clk); #1;
    t_ar = cycle;
    arvalid = 1'b0;
    rready  = 1'b1;
    cyc = 0;
    was_reset = 1'b0;
    while (exp_q.size() > 0 && cyc < 200 && !was_reset) begin
      if (mode == 2 && exp_q.size() == n - 2) begin
        rready = 1'b0;
        areset = 1'b1;
        @(posedge clk); #1;
        areset = 1'b0;
        exp_q.delete();
        exp_last_q.delete();
        was_reset = 1'b1;
        check("reset_err_wlast", DW'(err_wlast), DW'(0));
      end else begin
        @(posedge clk); #1;
        cyc++;
        if (mode == 1) rready = ~rready;
      end
    end
    rready = 1'b0;
    if (exp_q.size() > 0) begin
      fail_now("read_beats");
      exp_q.delete();
      exp_last_q.delete();
    end
    if (mode == 0) check("r_latency", DW'(cycle - t_ar), DW'(n));
    check("rvalid_idle", DW'(rvalid), DW'(0));
    check("arready_idle", DW'(arready), DW'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", DW'(awready), DW'(1));
    check("rst_arready", DW'(arready), DW'(1));
    check("rst_wready", DW'(wready), DW'(0));
    check("rst_bvalid", DW'(bvalid), DW'(0));
    check("rst_rvalid", DW'(rvalid), DW'(0));
    check("rst_rlast", DW'(rlast), DW'(0));
    check("rst_rdata", rdata, '0);
    check("rst_err_wlast", DW'(err_wlast), DW'(0));
    areset = 1'b0;
    @(posedge clk); #1;

    wq.push_back({64{8'hA5}});
    sq.push_back({NB{1'b1}});
    do_write(64'h40, -1, 0);
    do_read(64'h40, 1, 0);
    check("lit_single", got_q[0], {64{8'hA5}});

    for (int i = 0; i < 16; i++) begin
      wq.push_back(DW'(i));
      sq.push_back({NB{1'b1}});
    end
    do_write(64'(1020 * 64), -1, 5);
    do_read(64'(1020 * 64), 16, 0);
    check("lit_burst_b4", got_q[4], DW'(4));
    check("lit_burst_b15", got_q[15], DW'(15));

    do_read(64'(1020 * 64), 8, 1);
    check("lit_bp_b7", got_q[7], DW'(7));

    wq.push_back({64{8'hFF}});
    sq.push_back({NB{1'b1}});
    do_write(64'(3 * 64), -1, 0);
    wq.push_back('0);
    sq.push_back(NB'(64'hF));
    do_write(64'(3 * 64), -1, 0);
    do_read(64'(3 * 64), 1, 0);
    check("lit_partial", got_q[0], {{60{8'hFF}}, 32'h0});
    check("err_wlast_clean", DW'(err_wlast), DW'(0));

    for (int i = 0; i < 4; i++) begin
      wq.push_back(DW'(100 + i));
      sq.push_back({NB{1'b1}});
    end
    do_write(64'(32 * 64), 1, 0);
    check("err_wlast_set", DW'(err_wlast), DW'(1));
    do_read(64'(32 * 64), 4, 0);
    check("lit_wlast_b3", got_q[3], DW'(103));
    check("err_wlast_sticky", DW'(err_wlast), DW'(1));

    do_read(64'(1020 * 64), 8, 2);
    do_read(64'(1020 * 64), 16, 0);
    check("lit_after_rst_b0", got_q[0], DW'(0));
    check("lit_after_rst_b15", got_q[15], DW'(15));

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axonerve_wordcount_axi_mem_slave.md
Name: axonerve_wordcount_axi_mem_slave

Overview:
- AXI4 slave responder backed by on-chip memory, one word per data-bus width.
- Acts as the far end of the wordcount kernel's m00_axi master port: it answers AR/R bursts from the read master and AW/W/B bursts from the write master.
- Used as the memory model in kernel-level benches and as a scratch buffer in standalone builds.
- Read and write paths are independent. Each path accepts one burst at a time.

Parameters:
- C_S_AXI_ADDR_WIDTH, 64, byte-address width of awaddr/araddr.
- C_S_AXI_DATA_WIDTH, 512, data width in bits; must be a power of 2 and at least 32.
- C_MEM_DEPTH, 1024, number of data-width words; must be a power of 2.

Ports:
- ap_clk  in  1  single clock.
- areset  in  1  synchronous, active-high reset.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write burst start byte address.
- s_axi_awlen  in  8  write beats minus 1.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_wdata  in  C_S_AXI_DATA_WIDTH  write data.
- s_axi_wstrb  in  C_S_AXI_DATA_WIDTH/8  byte enables.
- s_axi_wlast  in  1  last write beat marker.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read burst start byte address.
- s_axi_arlen  in  8  read beats minus 1.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.
- s_axi_rdata  out  C_S_AXI_DATA_WIDTH  read data.
- s_axi_rlast  out  1  last read beat marker.
- err_wlast  out  1  sticky flag: wlast disagreed with awlen.

Behaviour:
- Word index = addr[LSB +: log2(C_MEM_DEPTH)], where LSB = log2(C_S_AXI_DATA_WIDTH/8).
  - Low address bits are ignored.
  - Upper address bits are ignored, so addresses alias modulo the memory size.
  - Burst type is INCR only. The index increments by 1 per beat and wraps from C_MEM_DEPTH-1 to 0.
- Reset values: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, rdata=0, err_wlast=0.
  - Memory contents are not cleared by reset.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: awready=1. On awvalid&awready, latch the index and beat count (awlen+1). Next state W_DATA; awready=0.
  - W_DATA: wready=1. Each wvalid&wready beat writes the bytes enabled by wstrb to mem[index], then index+1. On the beat whose count reaches awlen+1, go to W_RESP.
  - wlast is checked but does not steer the FSM: if wlast != (beat is last per awlen), set err_wlast. err_wlast clears only on reset. Burst length always follows awlen.
  - W_RESP: bvalid=1, held until bready. On bvalid&bready, return to W_IDLE with awready=1 the next cycle.
  - Minimum write burst timing: AW at T, first W accepted at T+1, bvalid at T+1+N.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: arready=1. On arvalid&arready at cycle T: rdata <= mem[index], rvalid=1 and rlast=(arlen==0) from T+1. Next state R_DATA.
  - R_DATA: rdata, rvalid and rlast stay stable while rvalid&~rready.
  - On rvalid&rready of a non-last beat: rdata <= mem[index+1] and rlast updates, giving back-to-back beats when rready is held high.
  - On rvalid&rready of the last beat: rvalid=0, return to R_IDLE, arready=1 from the next cycle.
- Simultaneous write and read of the same word in one cycle: read returns old data (read-first). Byte lanes with wstrb=0 are unchanged.
- The read and write FSMs run concurrently with no ordering between them. The AR and AW channels may handshake in the same cycle.
- areset mid-burst: both FSMs return to idle and all valids drop on the next edge. Partially written bursts remain in memory.

Test Plan:
- Single-beat write: awaddr=0x40, awlen=0, wdata=0xA5.., wstrb all-ones, wlast=1, bready=1 → bvalid 2 cycles after AW handshake. Read of 0x40 with arlen=0 returns the same data, rlast=1.
- 16-beat burst at word 1020 (C_MEM_DEPTH=1024): write beat i = i → words 1020..1023 and 0..11 hold 0..15. A 16-beat read returns 0..15 back-to-back with rready=1; rlast only on beat 15.
- Backpressure: toggle rready 1/0 every cycle during an 8-beat read → rdata/rlast stable while stalled, no beat lost or duplicated. Hold bready=0 for 5 cycles → bvalid stays high and awready stays 0.
- Partial strobe: preload word 3 with all 0xFF; write wstrb=0x...0F with wdata=0 → low 4 bytes 0x00, other bytes 0xFF on readback.
- wlast error: awlen=3 with wlast asserted on beat 1 → 4 beats still accepted, err_wlast=1 until areset.
- Reset mid-read: assert areset after beat 2 of an 8-beat read → rvalid=0 and arready=1 after reset; a new read works and memory data is intact.
